// File: rtl/cmp_pkg.sv
// Shared types and compare-code constants for the iterative comparator and its consumer.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [2:0] CMP_SLT = 3'b000;
    localparam logic [2:0] CMP_SGT = 3'b001;
    localparam logic [2:0] CMP_SLE = 3'b010;
    localparam logic [2:0] CMP_SGE = 3'b011;
    localparam logic [2:0] CMP_SNE = 3'b100;
    localparam logic [2:0] CMP_SEQ = 3'b110;

endpackage

// File: rtl/sub_slice.sv
// One slice of the subtractor: a + ~b + cin, with carry-out and carry into the slice MSB.
module sub_slice #(
    parameter int unsigned SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum_c,
    output logic             cout_c,
    output logic             c_top_c
);

    localparam int unsigned SW = SLICE + 1;

    logic [SLICE:0] full;

    // Widened add so the carry-out falls out as the top bit.
    assign full    = {1'b0, a} + {1'b0, ~b} + SW'(cin);
    assign sum_c   = full[SLICE-1:0];
    assign cout_c  = full[SLICE];
    // Carry into the top bit recovered from the top sum bit and its two addend bits.
    assign c_top_c = full[SLICE-1] ^ a[SLICE-1] ^ ~b[SLICE-1];

endmodule

// File: rtl/iter_cmp_unit.sv
// Multi-cycle signed comparator: subtracts SLICE bits per cycle and reports less/equal.
module iter_cmp_unit
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [2:0]       bonus_i,
    input  logic             comp_i,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic             less_o,
    output logic             equal_o,
    output logic [2:0]       bonus_o,
    output logic             comp_o
);

    localparam int unsigned N     = WIDTH / SLICE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               zero_acc;
    logic [2:0]         bonus_lat;
    logic               comp_lat;
    logic [SLICE-1:0]   sum_c;
    logic               cout_c;
    logic               c_top_c;
    logic               last_c;

    sub_slice #(.SLICE(SLICE)) u_sub_slice (
        .a       (a_q[SLICE-1:0]),
        .b       (b_q[SLICE-1:0]),
        .cin     (carry),
        .sum_c   (sum_c),
        .cout_c  (cout_c),
        .c_top_c (c_top_c)
    );

    assign last_c = (cnt == CNT_W'(N - 1));

    // State register; busy/valid are registered from the next state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            state   <= state_nx;
            busy_o  <= (state_nx != IDLE);
            valid_o <= (state_nx == DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_i) state_nx = RUN;
            RUN:     if (last_c)  state_nx = DONE;
            DONE:    if (ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand shifting, carry/zero accumulation and result capture.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            zero_acc  <= 1'b0;
            bonus_lat <= 3'b000;
            comp_lat  <= 1'b0;
            less_o    <= 1'b0;
            equal_o   <= 1'b0;
            bonus_o   <= 3'b000;
            comp_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        a_q       <= src1_i;
                        b_q       <= src2_i;
                        bonus_lat <= bonus_i;
                        comp_lat  <= comp_i;
                        cnt       <= '0;
                        carry     <= 1'b1;
                        zero_acc  <= 1'b1;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> SLICE;
                    b_q      <= b_q >> SLICE;
                    carry    <= cout_c;
                    zero_acc <= zero_acc & (sum_c == '0);
                    cnt      <= cnt + CNT_W'(1);
                    if (last_c) begin
                        cnt     <= '0;
                        // Overflow-corrected sign of A - B.
                        less_o  <= sum_c[SLICE-1] ^ (c_top_c ^ cout_c);
                        equal_o <= zero_acc & (sum_c == '0);
                        bonus_o <= bonus_lat;
                        comp_o  <= comp_lat;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iter_cmp_unit.sv
// Self-checking bench for iter_cmp_unit: directed cases plus randomized traffic vs a transaction model.
module tb_iter_cmp_unit;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N     = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [2:0]       bonus_i;
    logic             comp_i;
    logic             ready_i;
    logic             busy_o;
    logic             valid_o;
    logic             less_o;
    logic             equal_o;
    logic [2:0]       bonus_o;
    logic             comp_o;

    int vectors     = 0;
    int miscompares = 0;

    iter_cmp_unit #(.WIDTH(WIDTH), .SLICE(4)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .src1_i  (src1_i),
        .src2_i  (src2_i),
        .bonus_i (bonus_i),
        .comp_i  (comp_i),
        .ready_i (ready_i),
        .busy_o  (busy_o),
        .valid_o (valid_o),
        .less_o  (less_o),
        .equal_o (equal_o),
        .bonus_o (bonus_o),
        .comp_o  (comp_o)
    );

    always #5 clk_i = ~clk_i;

    // Transaction-level model: phase 0 idle, 1 computing, 2 result offered.
    int         m_phase = 0;
    int         m_left  = 0;
    logic       p_less  = 1'b0;
    logic       p_eq    = 1'b0;
    logic [2:0] p_bonus = 3'b000;
    logic       p_comp  = 1'b0;
    logic       m_less  = 1'b0;
    logic       m_eq    = 1'b0;
    logic [2:0] m_bonus = 3'b000;
    logic       m_comp  = 1'b0;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_phase <= 0;
            m_left  <= 0;
            m_less  <= 1'b0;
            m_eq    <= 1'b0;
            m_bonus <= 3'b000;
            m_comp  <= 1'b0;
        end else begin
            case (m_phase)
                0: if (start_i) begin
                    p_less  <= $signed(src1_i) < $signed(src2_i);
                    p_eq    <= (src1_i == src2_i);
                    p_bonus <= bonus_i;
                    p_comp  <= comp_i;
                    m_left  <= N;
                    m_phase <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_phase <= 2;
                        m_less  <= p_less;
                        m_eq    <= p_eq;
                        m_bonus <= p_bonus;
                        m_comp  <= p_comp;
                    end
                end
                default: if (ready_i) m_phase <= 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_vec();
        return {busy_o, valid_o, less_o, equal_o, bonus_o, comp_o};
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk_i) begin
        check("cycle", 32'(dut_vec()),
              32'({(m_phase != 0), (m_phase == 2), m_less, m_eq, m_bonus, m_comp}));
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] bo, input logic cm);
        @(posedge clk_i) #1;
        src1_i  = a;
        src2_i  = b;
        bonus_i = bo;
        comp_i  = cm;
        start_i = 1'b1;
        @(posedge clk_i) #1;
        start_i = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!valid_o && cycles < 50) begin
            @(posedge clk_i) #1;
            cycles++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] bo,
                          input logic cm, input logic el, input logic ee);
        int cyc;
        start_op(a, b, bo, cm);
        wait_valid(cyc);
        check("latency", 32'(cyc), 32'(N));
        check("less", 32'(less_o), 32'(el));
        check("equal", 32'(equal_o), 32'(ee));
        check("bonus", 32'(bonus_o), 32'(bo));
        check("comp", 32'(comp_o), 32'(cm));
        ready_i = 1'b1;
        @(posedge clk_i) #1;
        ready_i = 1'b0;
        check("release", 32'({busy_o, valid_o}), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        rst_i   = 1'b1;
        start_i = 1'b0;
        ready_i = 1'b0;
        src1_i  = '0;
        src2_i  = '0;
        bonus_i = 3'b000;
        comp_i  = 1'b0;
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("reset", 32'(dut_vec()), 32'd0);
        @(posedge clk_i) #1;
        rst_i = 1'b1;

        run_op(32'd5, 32'd7, 3'b000, 1'b1, 1'b1, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 3'b001, 1'b0, 1'b1, 1'b0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b010, 1'b1, 1'b0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h7FFF_FFFF, 3'b100, 1'b0, 1'b1, 1'b0);
        run_op(32'h1234_5678, 32'h1234_5678, 3'b110, 1'b1, 1'b0, 1'b1);

        // Backpressure: result held, start ignored while waiting for ready.
        start_op(32'd100, 32'hFFFF_FF9C, 3'b011, 1'b0);
        wait_valid(cyc);
        check("bp_latency", 32'(cyc), 32'(N));
        for (int i = 0; i < 5; i++) begin
            start_i = (i == 2);
            src1_i  = 32'd1;
            src2_i  = 32'd2;
            @(posedge clk_i) #1;
            check("bp_hold", 32'(dut_vec()), 32'({1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 1'b0}));
        end
        start_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i) #1;
        ready_i = 1'b0;
        check("bp_release", 32'({busy_o, valid_o}), 32'd0);
        @(posedge clk_i) #1;
        check("bp_idle", 32'(busy_o), 32'd0);

        // Reset mid-RUN aborts and clears everything, then a fresh op works.
        start_op(32'd1, 32'd1, 3'b111, 1'b1);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1 check("mid_reset", 32'(dut_vec()), 32'd0);
        @(posedge clk_i) #1;
        rst_i = 1'b1;
        run_op(32'hFFFF_FFFD, 32'd2, 3'b000, 1'b1, 1'b1, 1'b0);

        // Randomized traffic; the every-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_i) #1;
            src1_i  = pick();
            src2_i  = ($urandom_range(0, 3) == 0) ? src1_i : pick();
            bonus_i = 3'($urandom);
            comp_i  = 1'($urandom);
            start_i = ($urandom_range(0, 2) == 0);
            ready_i = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 299) == 0) begin
                rst_i = 1'b0;
                #2 rst_i = 1'b1;
            end
        end
        start_i = 1'b0;
        ready_i = 1'b0;
        @(negedge clk_i);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
